neuron_mac_gen: RTL and testbench

NEURON_MAC_GEN -- requirements
Module: neuron_mac_gen

---
 rtl/neuron_mac_gen.sv | 184 ++++++++++++++++++
 tb/tb_neuron_mac_gen.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_gen.sv
// neuron_mac_gen: one neuron of a fixed-point layer. Weights are streamed in
// once and kept in per-lane banks. Input vectors then arrive in beats of LANES
// words. Each beat goes through a weight read, a registered product and an
// accumulate stage. After the last beat the FSM drains the pipeline, adds the
// bias, shifts down by FRAC_W, saturates, applies the activation and emits one
// result strobe.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cfg_layer, cfg_neuron select this neuron for w_valid / b_valid
//   w_valid, w_data       weight word write (IDLE only, auto-increment address)
//   b_valid, b_data       bias word write (any state)
//   in_valid, in_ready    input beat handshake; in_data lane 0 in LSBs
//   out_data, out_valid   activated result and its one-cycle strobe
//   busy                  vector in flight
//   ovf                   sticky saturation flag
//   wr_err                one-cycle pulse for a dropped weight write

// One MAC lane. It holds the weights for beat positions of its lane and
// produces the registered product two cycles after a read.
module neuron_mac_lane #(
  parameter int DATA_W = 16,
  parameter int BEATS  = 128,
  parameter int BW     = 7
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [BW-1:0]         waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  rd,
  input  logic [BW-1:0]         raddr,
  input  logic [DATA_W-1:0]     x,
  output logic [2*DATA_W-1:0]   prod
);
  // No reset on the bank: weights survive rst.
  logic        [DATA_W-1:0] mem [BEATS];
  logic signed [DATA_W-1:0] w_q, x_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (rd) begin
      w_q <= mem[raddr];
      x_q <= x;
    end
    prod <= w_q * x_q;
  end
endmodule

module neuron_mac_gen #(
  parameter int LAYER_NO   = 1,
  parameter int NEURON_NO  = 0,
  parameter int NUM_WEIGHT = 128,
  parameter int LANES      = 1,
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 8,
  parameter     ACT        = "relu"
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               cfg_layer,
  input  logic [7:0]               cfg_neuron,
  input  logic                     w_valid,
  input  logic [DATA_W-1:0]        w_data,
  input  logic                     b_valid,
  input  logic [DATA_W-1:0]        b_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*DATA_W-1:0]  in_data,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     ovf,
  output logic                     wr_err
);
  localparam int BEATS  = NUM_WEIGHT / LANES;
  localparam int ACC_W  = 2*DATA_W + $clog2(NUM_WEIGHT);
  localparam int AW     = $clog2(NUM_WEIGHT);
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LSH    = $clog2(LANES);
  localparam int STAGES = 2;
  localparam bit RELU   = (ACT == "relu");

  typedef enum logic [2:0] {S_IDLE, S_ACC, S_DRAIN, S_BIAS, S_ACT} state_t;

  state_t                      state;
  logic signed [ACC_W-1:0]     acc, bias, lane_sum, r;
  logic [BW-1:0]               beat_cnt, w_idx;
  logic [AW-1:0]               w_addr;
  logic [STAGES-1:0]           vld_pipe;
  logic [LANES-1:0]            lane_we;
  logic [LANES-1:0][2*DATA_W-1:0] prod;
  logic                        sel, accept, beat_last, w_wr, clip;
  logic [ACC_W-DATA_W:0]       top_bits;
  logic [DATA_W-1:0]           sat_val, act_val;

  assign sel       = (cfg_layer == 8'(LAYER_NO)) && (cfg_neuron == 8'(NEURON_NO));
  assign in_ready  = !rst && (state == S_IDLE || state == S_ACC);
  assign accept    = in_valid && in_ready;
  assign beat_last = (beat_cnt == BW'(BEATS-1));
  assign w_wr      = w_valid && sel && (state == S_IDLE);
  assign w_idx     = BW'(w_addr >> LSH);
  assign busy      = (state != S_IDLE);

  // Address k lives in lane k%LANES at index k/LANES.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_we[l] = w_wr && (LANES == 1 || (w_addr % AW'(LANES)) == AW'(l));
    neuron_mac_lane #(.DATA_W(DATA_W), .BEATS(BEATS), .BW(BW)) u_lane (
      .clk   (clk),
      .we    (lane_we[l]),
      .waddr (w_idx),
      .wdata (w_data),
      .rd    (accept),
      .raddr (beat_cnt),
      .x     (in_data[l*DATA_W +: DATA_W]),
      .prod  (prod[l])
    );
  end

  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++)
      lane_sum = lane_sum + {{(ACC_W-2*DATA_W){prod[l][2*DATA_W-1]}}, prod[l]};
  end

  // Result fits DATA_W only if every bit from the DATA_W-1 sign position up
  // is a copy of the sign.
  assign r        = acc >>> FRAC_W;
  assign top_bits = r[ACC_W-1:DATA_W-1];
  assign clip     = !((&top_bits) || !(|top_bits));
  assign sat_val  = clip ? (r[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                       : {1'b0, {(DATA_W-1){1'b1}}})
                         : r[DATA_W-1:0];
  assign act_val  = (RELU && sat_val[DATA_W-1]) ? '0 : sat_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      bias      <= '0;
      beat_cnt  <= '0;
      w_addr    <= '0;
      vld_pipe  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      wr_err    <= w_valid && sel && (state != S_IDLE);
      vld_pipe  <= {vld_pipe[STAGES-2:0], accept};

      if (w_wr)
        w_addr <= (w_addr == AW'(NUM_WEIGHT-1)) ? '0 : w_addr + 1'b1;
      if (b_valid && sel)
        bias <= {{(ACC_W-DATA_W){b_data[DATA_W-1]}}, b_data} << FRAC_W;
      if (accept)
        beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
      if (vld_pipe[STAGES-1])
        acc <= acc + lane_sum;

      case (state)
        S_IDLE: if (accept) begin
          acc   <= '0;
          state <= beat_last ? S_DRAIN : S_ACC;
        end
        S_ACC: if (accept && beat_last) state <= S_DRAIN;
        // The last product is accumulated on the edge where stage 1 is
        // already empty, so leaving then sees the final sum in BIAS.
        S_DRAIN: if (!vld_pipe[0]) state <= S_BIAS;
        S_BIAS: begin
          acc   <= acc + bias;
          state <= S_ACT;
        end
        S_ACT: begin
          out_data  <= act_val;
          out_valid <= 1'b1;
          if (clip) ovf <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_mac_gen.sv
module tb_neuron_mac_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, w_valid, b_valid;
  logic [7:0]  cfg_layer, cfg_neuron;
  logic [15:0] w_data, b_data;
  logic        in_valid_a, in_ready_a, out_valid_a, busy_a, ovf_a, wr_err_a;
  logic [15:0] in_data_a, out_data_a;
  logic        in_valid_b, in_ready_b, out_valid_b, busy_b, ovf_b, wr_err_b;
  logic [63:0] in_data_b;
  logic [15:0] out_data_b;

  neuron_mac_gen #(.LAYER_NO(1), .NEURON_NO(0), .NUM_WEIGHT(4), .LANES(1),
                   .DATA_W(16), .FRAC_W(8), .ACT("relu")) dut_a (
    .clk(clk), .rst(rst), .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron),
    .w_valid(w_valid), .w_data(w_data), .b_valid(b_valid), .b_data(b_data),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .busy(busy_a),
    .ovf(ovf_a), .wr_err(wr_err_a));

  neuron_mac_gen #(.LAYER_NO(1), .NEURON_NO(1), .NUM_WEIGHT(8), .LANES(4),
                   .DATA_W(16), .FRAC_W(8), .ACT("none")) dut_b (
    .clk(clk), .rst(rst), .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron),
    .w_valid(w_valid), .w_data(w_data), .b_valid(b_valid), .b_data(b_data),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .busy(busy_b),
    .ovf(ovf_b), .wr_err(wr_err_b));

  int n_cmp = 0, n_bad = 0;
  int npulse_a = 0, npulse_b = 0;
  int wa[4], wb[8];
  int bias_a = 0, bias_b = 0;
  bit ovf_exp_a = 0, ovf_exp_b = 0;

  always @(posedge clk) begin
    if (out_valid_a) npulse_a++;
    if (out_valid_b) npulse_b++;
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  // Reference: real-valued neuron in fixed point. dot is the exact integer sum
  // of products, the bias is scaled to the product's binary point.
  function automatic longint shifted(input longint dot, input int bias);
    return (dot + longint'(bias) * 256) >>> 8;
  endfunction
  function automatic logic [15:0] activate(input longint r, input bit relu);
    longint s = r;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return 16'(s);
  endfunction
  function automatic bit clips(input longint r);
    return (r > 32767) || (r < -32768);
  endfunction

  task automatic load_a;
    for (int i = 0; i < 4; i++) begin
      cfg_neuron = 8'd0; w_valid = 1'b1; w_data = 16'(wa[i]); step;
    end
    w_valid = 1'b0;
  endtask
  task automatic load_b;
    for (int i = 0; i < 8; i++) begin
      cfg_neuron = 8'd1; w_valid = 1'b1; w_data = 16'(wb[i]); step;
    end
    w_valid = 1'b0;
  endtask
  task automatic set_bias(input int nrn, input int val);
    cfg_neuron = 8'(nrn); b_valid = 1'b1; b_data = 16'(val); step;
    b_valid = 1'b0;
    if (nrn == 0) bias_a = val; else bias_b = val;
  endtask

  // Feed one vector, then wait (bounded) for the result. lat counts cycles
  // from the edge that accepted the last beat; returns the cycle after
  // out_valid so the next vector can follow back-to-back.
  task automatic run_a(input int x[4], input int gap, output logic [15:0] got,
                       output int lat, output int pulses, output bit busy1);
    int p0 = npulse_a;
    got = '0;
    for (int i = 0; i < 4; i++) begin
      in_valid_a = 1'b0;
      if (i > 0) repeat (gap) step;
      in_valid_a = 1'b1; in_data_a = 16'(x[i]);
      for (int g = 0; g < 20 && !in_ready_a; g++) step;
      step;
    end
    in_valid_a = 1'b0;
    lat = -1; busy1 = busy_a;
    for (int n = 1; n <= 12 && lat < 0; n++) begin
      if (out_valid_a) begin lat = n; got = out_data_a; end
      step;
    end
    pulses = npulse_a - p0;
  endtask

  task automatic run_b(input int x[8], input int gap, output logic [15:0] got,
                       output int lat, output int pulses);
    int p0 = npulse_b;
    got = '0;
    for (int j = 0; j < 2; j++) begin
      in_valid_b = 1'b0;
      if (j > 0) repeat (gap) step;
      in_valid_b = 1'b1;
      for (int l = 0; l < 4; l++) in_data_b[l*16 +: 16] = 16'(x[4*j+l]);
      for (int g = 0; g < 20 && !in_ready_b; g++) step;
      step;
    end
    in_valid_b = 1'b0;
    lat = -1;
    for (int n = 1; n <= 12 && lat < 0; n++) begin
      if (out_valid_b) begin lat = n; got = out_data_b; end
      step;
    end
    pulses = npulse_b - p0;
  endtask

  // Runs a vector on A and checks it against the reference model.
  task automatic check_vec_a(input string tag, input int x[4], input int gap);
    logic [15:0] got, exp; int lat, pulses; bit b1; longint dot = 0, r;
    for (int i = 0; i < 4; i++) dot += longint'(wa[i]) * x[i];
    r = shifted(dot, bias_a); exp = activate(r, 1'b1);
    ovf_exp_a = ovf_exp_a | clips(r);
    run_a(x, gap, got, lat, pulses, b1);
    n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL %s out got %h want %h", tag, got, exp); end
    n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL %s latency got %0d want 5", tag, lat); end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL %s pulses got %0d want 1", tag, pulses); end
    n_cmp++; if (ovf_a !== ovf_exp_a) begin n_bad++; $display("FAIL %s ovf got %b want %b", tag, ovf_a, ovf_exp_a); end
    n_cmp++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL %s busy got %b want 1", tag, b1); end
  endtask

  task automatic check_vec_b(input string tag, input int x[8], input int gap);
    logic [15:0] got, exp; int lat, pulses; longint dot = 0, r;
    for (int i = 0; i < 8; i++) dot += longint'(wb[i]) * x[i];
    r = shifted(dot, bias_b); exp = activate(r, 1'b0);
    ovf_exp_b = ovf_exp_b | clips(r);
    run_b(x, gap, got, lat, pulses);
    n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL %s out got %h want %h", tag, got, exp); end
    n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL %s latency got %0d want 5", tag, lat); end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL %s pulses got %0d want 1", tag, pulses); end
    n_cmp++; if (ovf_b !== ovf_exp_b) begin n_bad++; $display("FAIL %s ovf got %b want %b", tag, ovf_b, ovf_exp_b); end
  endtask

  task automatic test_reset;
    rst = 1'b1; step; step;
    n_cmp++; if (in_ready_a !== 1'b0 || in_ready_b !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b%b want 00", in_ready_a, in_ready_b); end
    n_cmp++; if ({out_valid_a, busy_a, ovf_a, wr_err_a} !== 4'b0) begin n_bad++; $display("FAIL reset_flags got %b want 0000", {out_valid_a, busy_a, ovf_a, wr_err_a}); end
    n_cmp++; if (out_data_a !== 16'h0) begin n_bad++; $display("FAIL reset_out got %h want 0000", out_data_a); end
    rst = 1'b0; step;
    n_cmp++; if (in_ready_a !== 1'b1 || busy_a !== 1'b0) begin n_bad++; $display("FAIL post_reset got ready %b busy %b want 1 0", in_ready_a, busy_a); end
    bias_a = 0; bias_b = 0; ovf_exp_a = 0; ovf_exp_b = 0;
  endtask

  task automatic test_basic;
    logic [15:0] got; int lat, pulses; bit b1;
    wa = '{256, 256, 256, 256}; load_a; set_bias(0, 0);
    run_a('{128, 128, 128, 128}, 0, got, lat, pulses, b1);
    n_cmp++; if (got !== 16'h0200) begin n_bad++; $display("FAIL basic out got %h want 0200", got); end
    n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL basic latency got %0d want 5", lat); end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL basic pulses got %0d want 1", pulses); end
  endtask

  task automatic test_lanes;
    logic [15:0] got; int lat, pulses;
    wb = '{256, 256, 256, 256, 256, 256, 256, 256}; load_b; set_bias(1, 0);
    run_b('{128, 128, 128, 128, 128, 128, 128, 128}, 3, got, lat, pulses);
    n_cmp++; if (got !== 16'h0400) begin n_bad++; $display("FAIL lanes out got %h want 0400", got); end
    n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL lanes latency got %0d want 5", lat); end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL lanes pulses got %0d want 1", pulses); end
  endtask

  task automatic test_act;
    check_vec_a("relu_neg", '{-256, -256, -256, -256}, 0);
    check_vec_b("none_neg", '{-256, -256, -256, -256, -256, -256, -256, -256}, 1);
  endtask

  task automatic test_wr_err;
    int lat = -1; logic [15:0] got = '0;
    wa = '{256, 256, 256, 256}; load_a;
    in_valid_a = 1'b1; in_data_a = 16'h0080; step;
    cfg_neuron = 8'd0; w_valid = 1'b1; w_data = 16'h7000; step;
    w_valid = 1'b0;
    n_cmp++; if (wr_err_a !== 1'b1 || wr_err_b !== 1'b0) begin n_bad++; $display("FAIL wr_err_pulse got %b%b want 10", wr_err_a, wr_err_b); end
    step;
    n_cmp++; if (wr_err_a !== 1'b0) begin n_bad++; $display("FAIL wr_err_width got %b want 0", wr_err_a); end
    step; in_valid_a = 1'b0;
    for (int n = 1; n <= 12 && lat < 0; n++) begin
      if (out_valid_a) begin lat = n; got = out_data_a; end
      step;
    end
    n_cmp++; if (got !== 16'h0200 || lat != 5) begin n_bad++; $display("FAIL wr_err_result got %h lat %0d want 0200 lat 5", got, lat); end
    cfg_neuron = 8'd5; w_valid = 1'b1; w_data = 16'h7000; step;
    w_valid = 1'b0;
    n_cmp++; if (wr_err_a !== 1'b0 || wr_err_b !== 1'b0) begin n_bad++; $display("FAIL unselected_err got %b%b want 00", wr_err_a, wr_err_b); end
    check_vec_a("mem_kept", '{128, 128, 128, 128}, 0);
  endtask

  task automatic test_random;
    int x4[4]; int x8[8]; int span;
    for (int it = 0; it < 6; it++) begin
      span = (it == 3) ? 32768 : 512;
      for (int i = 0; i < 4; i++) wa[i] = int'($urandom_range(0, 2*span-1)) - span;
      for (int i = 0; i < 8; i++) wb[i] = int'($urandom_range(0, 2*span-1)) - span;
      for (int i = 0; i < 4; i++) x4[i] = int'($urandom_range(0, 2*span-1)) - span;
      for (int i = 0; i < 8; i++) x8[i] = int'($urandom_range(0, 2*span-1)) - span;
      load_a; load_b;
      set_bias(0, int'($urandom_range(0, 4095)) - 2048);
      set_bias(1, int'($urandom_range(0, 4095)) - 2048);
      check_vec_a("rand_a", x4, int'($urandom_range(0, 3)));
      check_vec_b("rand_b", x8, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_ovf;
    wa = '{32767, 32767, 32767, 32767}; load_a; set_bias(0, 0);
    check_vec_a("sat", '{32767, 32767, 32767, 32767}, 0);
    n_cmp++; if (ovf_a !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b want 1", ovf_a); end
    check_vec_a("ovf_sticky", '{0, 0, 0, 0}, 1);
  endtask

  task automatic test_back_to_back;
    wa = '{256, -512, 768, 100}; load_a; set_bias(0, 17);
    check_vec_a("b2b_0", '{300, 200, -100, 50}, 0);
    check_vec_a("b2b_1", '{-40, 90, 120, -700}, 0);
    check_vec_a("b2b_2", '{128, 128, 128, 128}, 0);
  endtask

  task automatic test_abort;
    int p0;
    wa = '{256, 256, 256, 256}; load_a; set_bias(0, 0);
    p0 = npulse_a;
    in_valid_a = 1'b1; in_data_a = 16'h0080; step; step;
    in_valid_a = 1'b0; rst = 1'b1; step; rst = 1'b0;
    bias_a = 0; bias_b = 0; ovf_exp_a = 0; ovf_exp_b = 0;
    repeat (8) step;
    n_cmp++; if (npulse_a != p0) begin n_bad++; $display("FAIL abort_pulse got %0d want 0", npulse_a - p0); end
    n_cmp++; if (ovf_a !== 1'b0 || busy_a !== 1'b0) begin n_bad++; $display("FAIL abort_state got ovf %b busy %b want 0 0", ovf_a, busy_a); end
    check_vec_a("after_abort", '{128, 128, 128, 128}, 0);
  endtask

  initial begin
    rst = 1'b1; cfg_layer = 8'd1; cfg_neuron = 8'd0;
    w_valid = 1'b0; w_data = '0; b_valid = 1'b0; b_data = '0;
    in_valid_a = 1'b0; in_data_a = '0; in_valid_b = 1'b0; in_data_b = '0;
    test_reset;
    test_basic;
    test_lanes;
    test_act;
    test_wr_err;
    test_random;
    test_ovf;
    test_back_to_back;
    test_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
